key_schedule_gen: RTL and testbench

Parametrised round-key generator, the next generation of the fixed three-key `Key_scheduler`. It accepts a KEY_W-bit master key through a valid/ready handshake and expands it into NUM_ROUNDS round keys of RK_W bits, one per enabled cycle. Each key is streamed out with an index and also stored in an internal register file, so the cipher datapath can read any round key at random. It sits between key loading and the round datapath of the cipher core.

---
 rtl/key_schedule_gen.sv | 133 +++++++++++++
 tb/tb_key_schedule_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_gen.sv
// key_schedule_gen: parametrised round-key generator.
// Accepts a master key via valid/ready, expands it into NUM_ROUNDS round keys
// by repeated left rotation, streams each key with its index and stores it in a
// register file for random-access reads.
// Optional feature: define KEYSCHED_RCON_EN to XOR each round key with its
// round number (round constant).
module key_schedule_gen #(
  parameter int KEY_W      = 16,
  parameter int RK_W       = 8,
  parameter int NUM_ROUNDS = 3,
  parameter int ROT        = 1,
  parameter int IDX_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [RK_W-1:0]  rk_out,
  output logic             rk_valid,
  output logic [IDX_W-1:0] rk_idx,
  output logic             busy,
  output logic             done,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [RK_W-1:0]  rd_key
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] s_q, s_d;
  logic [KEY_W-1:0] s_rot;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [RK_W-1:0]  keys_q [1:NUM_ROUNDS];
  logic [RK_W-1:0]  keys_d [1:NUM_ROUNDS];
  logic [RK_W-1:0]  rk;
  logic [RK_W-1:0]  rk_out_q, rk_out_d;
  logic [IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic             rk_valid_q, rk_valid_d;
  logic             last_round;

  // Next state value of S: left rotation by ROT bits.
  assign s_rot = {s_q[KEY_W-1-ROT:0], s_q[KEY_W-1 -: ROT]};

`ifdef KEYSCHED_RCON_EN
  assign rk = s_rot[KEY_W-1 -: RK_W] ^ RK_W'(cnt_q);
`else
  assign rk = s_rot[KEY_W-1 -: RK_W];
`endif

  assign last_round = (cnt_q == IDX_W'(NUM_ROUNDS));

  // A key can be taken whenever no expansion is in progress.
  assign key_ready = (state_q != ST_EXPAND);
  assign busy      = (state_q == ST_EXPAND);
  assign done      = (state_q == ST_DONE);
  assign rk_out    = rk_out_q;
  assign rk_idx    = rk_idx_q;
  assign rk_valid  = rk_valid_q;

  // Next-state logic: key accept, one round per enabled cycle, hold when en=0.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    keys_d     = keys_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (key_valid) begin
            s_d   = key_in;
            cnt_d = IDX_W'(1);
            for (int i = 1; i <= NUM_ROUNDS; i++) keys_d[i] = '0;
            state_d = ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          s_d = s_rot;
          for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (cnt_q == IDX_W'(i)) keys_d[i] = rk;
          end
          rk_out_d   = rk;
          rk_idx_d   = cnt_q;
          rk_valid_d = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (last_round) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      cnt_q      <= '0;
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      // NOTE: the key store is a small flop array that must read 0 after reset, so it is reset.
      for (int i = 1; i <= NUM_ROUNDS; i++) keys_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      keys_q     <= keys_d;
    end
  end

  // Random-access read; indices outside 1..NUM_ROUNDS return 0.
  always_comb begin
    rd_key = '0;
    for (int i = 1; i <= NUM_ROUNDS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_key = keys_q[i];
    end
  end

endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench for key_schedule_gen: directed scenarios plus randomized
// keys and enable patterns, checked against a rotation-based reference model.
module tb_key_schedule_gen;

  localparam int KW  = 16, RW  = 8,  NR  = 3, RT  = 1, IW  = 2;
  localparam int KW1 = 32, RW1 = 16, NR1 = 1, RT1 = 8, IW1 = 1;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic           en, key_valid, key_ready, rk_valid, busy, done;
  logic [KW-1:0]  key_in;
  logic [RW-1:0]  rk_out, rd_key;
  logic [IW-1:0]  rk_idx, rd_idx;

  logic           en1, key_valid1, key_ready1, rk_valid1, busy1, done1;
  logic [KW1-1:0] key_in1;
  logic [RW1-1:0] rk_out1, rd_key1;
  logic [IW1-1:0] rk_idx1, rd_idx1;

  int checks = 0;
  int errors = 0;
  logic [63:0] m_out;  // expected held rk_out
  int          m_idx;  // expected held rk_idx

  always #5 CLK = ~CLK;

  key_schedule_gen #(.KEY_W(KW), .RK_W(RW), .NUM_ROUNDS(NR), .ROT(RT), .IDX_W(IW)) dut (
    .CLK(CLK), .RST_N(RST_N), .en(en), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .rk_out(rk_out), .rk_valid(rk_valid), .rk_idx(rk_idx),
    .busy(busy), .done(done), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  key_schedule_gen #(.KEY_W(KW1), .RK_W(RW1), .NUM_ROUNDS(NR1), .ROT(RT1), .IDX_W(IW1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .en(en1), .key_in(key_in1), .key_valid(key_valid1),
    .key_ready(key_ready1), .rk_out(rk_out1), .rk_valid(rk_valid1), .rk_idx(rk_idx1),
    .busy(busy1), .done(done1), .rd_idx(rd_idx1), .rd_key(rd_key1)
  );

  // Round key r = top rw bits of the key rotated left by r*rot (mod kw).
  function automatic logic [63:0] ref_rk(input logic [63:0] key, input int kw, input int rw,
                                          input int rot, input int r);
    logic [63:0] mask, v, rotd, top;
    int sh;
    mask = (64'd1 << kw) - 64'd1;
    v    = key & mask;
    sh   = (r * rot) % kw;
    rotd = (sh == 0) ? v : (((v << sh) | (v >> (kw - sh))) & mask);
    top  = rotd >> (kw - rw);
`ifdef KEYSCHED_RCON_EN
    top  = (top ^ 64'(r)) & ((64'd1 << rw) - 64'd1);
`endif
    return top;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_rd(input int idx, input logic [63:0] exp);
    rd_idx = IW'(idx);
    #1;
    check($sformatf("rd_key[%0d]", idx), 64'(rd_key), exp);
  endtask

  task automatic check_reset_state();
    check("rst rk_out", 64'(rk_out), 64'h0);
    check("rst rk_valid", 64'(rk_valid), 64'h0);
    check("rst rk_idx", 64'(rk_idx), 64'h0);
    check("rst busy", 64'(busy), 64'h0);
    check("rst done", 64'(done), 64'h0);
    check("rst key_ready", 64'(key_ready), 64'h1);
    for (int i = 0; i <= NR; i++) check_rd(i, 64'h0);
  endtask

  task automatic accept_key(input logic [KW-1:0] key);
    key_in    = key;
    key_valid = 1'b1;
    en        = 1'b1;
    tick();
    key_valid = 1'b0;
    check("acc busy", 64'(busy), 64'h1);
    check("acc done", 64'(done), 64'h0);
    check("acc key_ready", 64'(key_ready), 64'h0);
    check("acc rk_valid", 64'(rk_valid), 64'h0);
    for (int i = 1; i <= NR; i++) check_rd(i, 64'h0);
  endtask

  // Drives the expansion after an accept; optional random en and key noise.
  task automatic run_sched(input logic [KW-1:0] key, input bit rand_en, input bit noise);
    int r = 0;
    int guard = 0;
    while (r < NR && guard < 200) begin
      en = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (noise) begin
        key_valid = 1'($urandom_range(0, 1));
        key_in    = KW'($urandom);
      end
      guard++;
      tick();
      if (en) begin
        r++;
        m_out = ref_rk(64'(key), KW, RW, RT, r);
        m_idx = r;
      end
      check($sformatf("rk_valid r%0d", r), 64'(rk_valid), 64'(en));
      check($sformatf("rk_out r%0d", r), 64'(rk_out), m_out);
      check($sformatf("rk_idx r%0d", r), 64'(rk_idx), 64'(m_idx));
      check($sformatf("busy r%0d", r), 64'(busy), 64'(r < NR));
      if (en) check_rd(r, m_out);
      if (r < NR) check_rd(NR, 64'h0);
    end
    key_valid = 1'b0;
    en        = 1'b1;
    if (r != NR) begin
      errors++;
      $display("FAIL sched_timeout rounds=%0d required=%0d", r, NR);
    end
    check("end done", 64'(done), 64'h1);
    check("end key_ready", 64'(key_ready), 64'h1);
    check("end busy", 64'(busy), 64'h0);
    for (int i = 1; i <= NR; i++) check_rd(i, ref_rk(64'(key), KW, RW, RT, i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] lit [1:3];
    logic [KW-1:0] k;
`ifdef KEYSCHED_RCON_EN
    lit[1] = 8'h4A; lit[2] = 8'h95; lit[3] = 8'h2D;
`else
    lit[1] = 8'h4B; lit[2] = 8'h97; lit[3] = 8'h2E;
`endif
    RST_N = 1'b0; en = 1'b0; key_valid = 1'b0; key_in = '0; rd_idx = '0;
    en1 = 1'b0; key_valid1 = 1'b0; key_in1 = '0; rd_idx1 = '0;
    m_out = '0; m_idx = 0;
    tick(); tick();
    check_reset_state();
    check("dut1 rst key_ready", 64'(key_ready1), 64'h1);
    check("dut1 rst rk_valid", 64'(rk_valid1), 64'h0);
    RST_N = 1'b1;
    tick();

    // Basic schedule for 0xA5C3 with a 0xFFFF key held on key_in during EXPAND.
    accept_key(16'hA5C3);
    key_in = 16'hFFFF; key_valid = 1'b1;
    run_sched(16'hA5C3, 1'b0, 1'b0);
    for (int i = 1; i <= NR; i++) check_rd(i, 64'(lit[i]));

    // Re-accept in DONE with 0xFFFF: stored keys cleared, then regenerated.
    accept_key(16'hFFFF);
    run_sched(16'hFFFF, 1'b0, 1'b0);

    // en low for two cycles after the first key.
    accept_key(16'hA5C3);
    tick();
    check("gap k1", 64'(rk_out), 64'(lit[1]));
    check("gap k1 valid", 64'(rk_valid), 64'h1);
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("gap stall valid", 64'(rk_valid), 64'h0);
      check("gap stall out", 64'(rk_out), 64'(lit[1]));
      check("gap stall idx", 64'(rk_idx), 64'h1);
      check("gap stall busy", 64'(busy), 64'h1);
    end
    en = 1'b1;
    for (int r = 2; r <= NR; r++) begin
      tick();
      check("gap valid", 64'(rk_valid), 64'h1);
      check("gap out", 64'(rk_out), 64'(lit[r]));
      check("gap idx", 64'(rk_idx), 64'(r));
    end
    tick();
    check("gap done", 64'(done), 64'h1);
    check("gap valid drop", 64'(rk_valid), 64'h0);

    // Reset in the cycle after the second key, then reload.
    accept_key(16'hA5C3);
    tick(); tick();
    check("pre-rst k2", 64'(rk_out), 64'(lit[2]));
    RST_N = 1'b0;
    tick();
    m_out = '0; m_idx = 0;
    check_reset_state();
    RST_N = 1'b1;
    tick();
    check("post-rst rk_valid", 64'(rk_valid), 64'h0);
    check("post-rst busy", 64'(busy), 64'h0);
    accept_key(16'hA5C3);
    run_sched(16'hA5C3, 1'b0, 1'b0);

    // Randomized keys, enable patterns and ignored key traffic.
    for (int t = 0; t < 15; t++) begin
      k = KW'($urandom);
      accept_key(k);
      run_sched(k, 1'b1, 1'b1);
    end

    // NUM_ROUNDS=1, KEY_W=32, RK_W=16, ROT=8 configuration.
    key_in1 = 32'h12345678; key_valid1 = 1'b1; en1 = 1'b1;
    tick();
    key_valid1 = 1'b0;
    check("dut1 busy", 64'(busy1), 64'h1);
    tick();
    check("dut1 rk_valid", 64'(rk_valid1), 64'h1);
    check("dut1 rk_idx", 64'(rk_idx1), 64'h1);
`ifdef KEYSCHED_RCON_EN
    check("dut1 rk_out", 64'(rk_out1), 64'h3457);
`else
    check("dut1 rk_out", 64'(rk_out1), 64'h3456);
`endif
    check("dut1 rk_out model", 64'(rk_out1), ref_rk(64'h12345678, KW1, RW1, RT1, 1));
    check("dut1 done", 64'(done1), 64'h1);
    check("dut1 busy end", 64'(busy1), 64'h0);
    rd_idx1 = 1'b1;
    #1;
    check("dut1 rd_key", 64'(rd_key1), ref_rk(64'h12345678, KW1, RW1, RT1, 1));
    tick();
    check("dut1 valid drop", 64'(rk_valid1), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
